// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive decoder: symbol width, the four
// control-token codes and the alignment state type.
package tmds_pkg;

  localparam int SYM_W = 10;

  // Control tokens as they appear in the 10-bit window (bit 0 received first)
  localparam logic [SYM_W-1:0] TOK_CTRL0 = 10'h354;  // {C1,C0} = 00
  localparam logic [SYM_W-1:0] TOK_CTRL1 = 10'h0AB;  // {C1,C0} = 01
  localparam logic [SYM_W-1:0] TOK_CTRL2 = 10'h154;  // {C1,C0} = 10
  localparam logic [SYM_W-1:0] TOK_CTRL3 = 10'h2AB;  // {C1,C0} = 11

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token recognition and the
// 10b->8b data inversion/XOR-XNOR unwind.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] symbol,
  output logic [7:0]       data,
  output logic [1:0]       ctrl,
  output logic             is_token
);

  logic [7:0] d;

  // Undo the optional inversion, then undo the XOR/XNOR chain bit by bit
  always_comb begin
    d    = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    data = 8'h00;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Match the window against the four control tokens
  always_comb begin
    ctrl     = 2'b00;
    is_token = 1'b0;
    case (symbol)
      TOK_CTRL0: begin ctrl = 2'b00; is_token = 1'b1; end
      TOK_CTRL1: begin ctrl = 2'b01; is_token = 1'b1; end
      TOK_CTRL2: begin ctrl = 2'b10; is_token = 1'b1; end
      TOK_CTRL3: begin ctrl = 2'b11; is_token = 1'b1; end
      default:   begin ctrl = 2'b00; is_token = 1'b0; end
    endcase
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS channel receive decoder: bit deserialiser, symbol alignment on
// control tokens, lock supervision and registered symbol output.
// Optional macro TMDS_RX_ERR_CNT_EN adds a saturating err_cnt output that
// counts alignment aborts and lock losses.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_HUNT    | search every bit position for any control token
//   ST_CONFIRM | boundary fixed; counting consecutive aligned tokens
//   ST_LOCKED  | aligned; decode and emit one symbol every 10 clocks
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS  = 8,
  parameter int LOSS_SYMBOLS = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        serial_in,
  output logic        sym_valid,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de_out,
  output logic        locked
`ifdef TMDS_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int RUN_W = $clog2(LOSS_SYMBOLS + 1);
  // Count value at which the next aligned token completes lock
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(LOCK_TOKENS - 1);
  // Run value at which the next data symbol exhausts the loss budget
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOSS_SYMBOLS - 1);

  rx_state_t        state;
  logic [SYM_W-1:0] sr;
  logic [SYM_W-1:0] win;
  logic [3:0]       phase;
  logic [TOK_W-1:0] tok_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             boundary;

  logic [7:0]       dec_data;
  logic [1:0]       dec_ctrl;
  logic             dec_is_token;

  // Window as it will be after this clock's bit is shifted in
  assign win      = {serial_in, sr[SYM_W-1:1]};
  assign boundary = (phase == 4'd9);

  tmds_symbol_decode u_decode (
    .symbol   (win),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_token (dec_is_token)
  );

  // Alignment FSM, phase counter, lock supervision and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_HUNT;
      sr        <= '0;
      phase     <= 4'd0;
      tok_cnt   <= '0;
      run_cnt   <= '0;
      sym_valid <= 1'b0;
      data_out  <= 8'h00;
      ctrl_out  <= 2'b00;
      de_out    <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sr        <= win;
      sym_valid <= 1'b0;
      case (state)
        ST_HUNT: begin
          phase    <= 4'd0;
          run_cnt  <= '0;
          data_out <= 8'h00;
          ctrl_out <= 2'b00;
          de_out   <= 1'b0;
          locked   <= 1'b0;
          if (dec_is_token) begin
            // This clock is a symbol boundary; the matched token counts as the first
            tok_cnt <= TOK_W'(1);
            if (LOCK_TOKENS <= 1) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              state <= ST_CONFIRM;
            end
          end else begin
            tok_cnt <= '0;
          end
        end

        ST_CONFIRM: begin
          phase <= boundary ? 4'd0 : phase + 4'd1;
          if (boundary) begin
            if (dec_is_token) begin
              if (tok_cnt == TOK_LAST) begin
                state   <= ST_LOCKED;
                locked  <= 1'b1;
                run_cnt <= '0;
              end else begin
                tok_cnt <= tok_cnt + TOK_W'(1);
              end
            end else begin
              state   <= ST_HUNT;
              tok_cnt <= '0;
            end
          end
        end

        ST_LOCKED: begin
          phase <= boundary ? 4'd0 : phase + 4'd1;
          if (boundary) begin
            sym_valid <= 1'b1;
            if (dec_is_token) begin
              de_out   <= 1'b0;
              ctrl_out <= dec_ctrl;
              run_cnt  <= '0;
            end else begin
              de_out   <= 1'b1;
              data_out <= dec_data;
              if (run_cnt == RUN_LAST) begin
                // Symbol still goes out; lock drops together with this pulse
                state   <= ST_HUNT;
                locked  <= 1'b0;
                run_cnt <= '0;
                tok_cnt <= '0;
              end else begin
                run_cnt <= run_cnt + RUN_W'(1);
              end
            end
          end
        end

        default: begin
          state  <= ST_HUNT;
          phase  <= 4'd0;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMDS_RX_ERR_CNT_EN
  logic abort_evt;
  logic loss_evt;

  assign abort_evt = (state == ST_CONFIRM) && boundary && !dec_is_token;
  assign loss_evt  = (state == ST_LOCKED) && boundary && !dec_is_token &&
                     (run_cnt == RUN_LAST);

  // Saturating count of alignment aborts and lock losses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_cnt <= 16'h0000;
    end else if ((abort_evt || loss_evt) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: reset, abort, lock, symbol spacing,
// decode, lock retention, lock loss and mid-symbol reset.
module tb_tmds_rx_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        serial_in;
  logic        sym_valid;
  logic [7:0]  data_out;
  logic [1:0]  ctrl_out;
  logic        de_out;
  logic        locked;
`ifdef TMDS_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  tmds_rx_decoder dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .serial_in (serial_in),
    .sym_valid (sym_valid),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .locked    (locked)
`ifdef TMDS_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick();
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) send_bit(s[i]);
  endtask

  initial begin
    int  pulses;
    logic lost;
    logic [9:0] tok;

    rst_in    = 1'b1;
    serial_in = 1'b0;

    // Reset held three clocks with random line data
    repeat (3) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_locked",    16'(locked),    16'd0);
    check("rst_sym_valid", 16'(sym_valid), 16'd0);
    check("rst_data",      16'(data_out),  16'd0);
    check("rst_ctrl",      16'(ctrl_out),  16'd0);
    check("rst_de",        16'(de_out),    16'd0);
`ifdef TMDS_RX_ERR_CNT_EN
    check("rst_err", err_cnt, 16'd0);
`endif
    rst_in = 1'b0;

    // Abort: five tokens then a data symbol during confirmation
    for (int i = 0; i < 5; i++) begin
      send_sym(10'h154);
      check("abort_tok_locked", 16'(locked),    16'd0);
      check("abort_tok_valid",  16'(sym_valid), 16'd0);
    end
    send_sym(10'h100);
    check("abort_locked", 16'(locked),    16'd0);
    check("abort_valid",  16'(sym_valid), 16'd0);
`ifdef TMDS_RX_ERR_CNT_EN
    check("abort_err", err_cnt, 16'd1);
`endif

    // Lock: three stray bits then eight tokens; count must restart after abort
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_sym(10'h354);
      if (i == 6) check("lock_after7", 16'(locked), 16'd0);
      check("lock_tok_valid", 16'(sym_valid), 16'd0);
    end
    check("lock_after8", 16'(locked), 16'd1);

    // First output symbol and exact 10-clock pulse spacing
    send_sym(10'h354);
    check("first_valid", 16'(sym_valid), 16'd1);
    check("first_de",    16'(de_out),    16'd0);
    check("first_ctrl",  16'(ctrl_out),  16'd0);
    check("first_data",  16'(data_out),  16'd0);
    tok = 10'h354;
    for (int i = 0; i < 10; i++) begin
      send_bit(tok[i]);
      check("spacing_valid", 16'(sym_valid), (i == 9) ? 16'd1 : 16'd0);
    end

    // Decode after lock, including hold behaviour of the unused field
    send_sym(10'h100);
    check("dec100_valid", 16'(sym_valid), 16'd1);
    check("dec100_de",    16'(de_out),    16'd1);
    check("dec100_data",  16'(data_out),  16'h00);
    send_sym(10'h2FF);
    check("dec2ff_data",  16'(data_out),  16'hFE);
    send_sym(10'h1FF);
    check("dec1ff_data",  16'(data_out),  16'h01);
    check("dec1ff_de",    16'(de_out),    16'd1);
    send_sym(10'h2AB);
    check("dec2ab_de",    16'(de_out),    16'd0);
    check("dec2ab_ctrl",  16'(ctrl_out),  16'd3);
    check("dec2ab_hold",  16'(data_out),  16'h01);
    send_sym(10'h100);
    check("hold_ctrl",    16'(ctrl_out),  16'd3);
    check("hold_data",    16'(data_out),  16'h00);
    send_sym(10'h0AB);
    check("dec0ab_ctrl",  16'(ctrl_out),  16'd1);
    check("dec0ab_de",    16'(de_out),    16'd0);

    // A token as the 1024th symbol keeps lock
    pulses = 0;
    lost   = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      send_sym(10'h100);
      if (sym_valid) pulses++;
      if (!locked) lost = 1'b1;
    end
    send_sym(10'h154);
    check("keep_pulses", 16'(pulses),    16'd1023);
    check("keep_lost",   16'(lost),      16'd0);
    check("keep_locked", 16'(locked),    16'd1);
    check("keep_ctrl",   16'(ctrl_out),  16'd2);
    check("keep_valid",  16'(sym_valid), 16'd1);

    // 1024 consecutive data symbols lose lock after the last is output
    pulses = 0;
    lost   = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      send_sym(10'h100);
      if (sym_valid) pulses++;
      if (i < 1023 && !locked) lost = 1'b1;
    end
    check("loss_last_valid", 16'(sym_valid), 16'd1);
    check("loss_last_de",    16'(de_out),    16'd1);
    check("loss_pulses",     16'(pulses),    16'd1024);
    check("loss_early",      16'(lost),      16'd0);
    send_bit(1'b0);
    check("loss_locked", 16'(locked),    16'd0);
    check("loss_valid",  16'(sym_valid), 16'd0);
    check("loss_de",     16'(de_out),    16'd0);
`ifdef TMDS_RX_ERR_CNT_EN
    check("loss_err", err_cnt, 16'd2);
`endif

    // Relock, then reset at phase 5 of a symbol
    for (int i = 0; i < 8; i++) send_sym(10'h354);
    check("relock_locked", 16'(locked), 16'd1);
    send_sym(10'h354);
    check("relock_valid", 16'(sym_valid), 16'd1);
    for (int i = 0; i < 5; i++) send_bit(tok[i]);
    rst_in = 1'b1;
    send_bit(1'b1);
    check("midrst_locked", 16'(locked),    16'd0);
    check("midrst_valid",  16'(sym_valid), 16'd0);
    check("midrst_ctrl",   16'(ctrl_out),  16'd0);
    check("midrst_de",     16'(de_out),    16'd0);
`ifdef TMDS_RX_ERR_CNT_EN
    check("midrst_err", err_cnt, 16'd0);
`endif
    rst_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_sym(10'h354);
      if (i == 6) check("fresh_after7", 16'(locked), 16'd0);
    end
    check("fresh_after8", 16'(locked), 16'd1);
    send_sym(10'h0AB);
    check("fresh_valid", 16'(sym_valid), 16'd1);
    check("fresh_ctrl",  16'(ctrl_out),  16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_rx_decoder.md
TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 8: consecutive aligned control tokens required to declare lock.
REQ-002 SHALL have parameter LOSS_SYMBOLS, default 1024: consecutive locked symbols without a control token that force lock loss.
REQ-003 SHALL have clk_in  input  1  TMDS bit clock; one serial bit is sampled per rising edge.
REQ-004 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have serial_in  input  1  TMDS channel bit stream, LSB of each 10-bit symbol first.
REQ-006 SHALL have sym_valid  output  1  one-cycle pulse per decoded symbol while locked.
REQ-007 SHALL have data_out  output  8  decoded pixel byte; valid with sym_valid when de_out=1.
REQ-008 SHALL have ctrl_out  output  2  decoded {C1,C0}; valid with sym_valid when de_out=0.
REQ-009 SHALL have de_out  output  1  1 = data symbol, 0 = control token.
REQ-010 SHALL have locked  output  1  symbol alignment achieved.

Function
REQ-011 SHALL shift serial_in into a 10-bit register as sr <= {serial_in, sr[9:1]}, so the first-received bit lands in q[0].
REQ-012 SHALL recognise control tokens 0x354->00, 0x0AB->01, 0x154->10, 0x2AB->11 (value = {C1,C0}).
REQ-013 SHALL implement FSM states HUNT, CONFIRM and LOCKED, plus a 0..9 phase counter that wraps 9->0.
REQ-014 HUNT: on any clock where the updated window equals a token, SHALL set phase=0 at that boundary, set token count=1 and go to CONFIRM.
REQ-015 CONFIRM: at each boundary (every 10th clock), a token SHALL increment the count; reaching LOCK_TOKENS SHALL enter LOCKED; a non-token SHALL return to HUNT.
REQ-016 LOCKED: at each boundary SHALL decode the symbol and pulse sym_valid exactly one clock after the boundary's 10th bit; consecutive pulses SHALL be exactly 10 clocks apart.
REQ-017 Decode SHALL use d = q[9] ? ~q[7:0] : q[7:0], data[0] = d[0], and data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i=1..7.
REQ-018 On a token, SHALL set de_out=0, set ctrl_out per REQ-012 and hold data_out; on a data symbol, SHALL set de_out=1 and hold ctrl_out.
REQ-019 LOCKED SHALL keep a run counter that clears on every token and increments on every data symbol; at LOSS_SYMBOLS it SHALL go to HUNT and deassert locked on the next clock.
REQ-020 The last symbol before lock loss SHALL still be output with sym_valid.
REQ-021 While not LOCKED, sym_valid, de_out, ctrl_out and data_out SHALL be 0.
REQ-022 Token matches seen in HUNT/CONFIRM SHALL NOT produce output.

Reset
REQ-023 rst_in=1 SHALL force state HUNT, phase, token count, run counter and sr to 0, and all outputs to 0 on the next clock edge, from any state.
REQ-024 Asserting reset mid-symbol SHALL discard the partial symbol; after release, a new hunt SHALL start with the next bit.

Configuration
REQ-025 With macro TMDS_RX_ERR_CNT_EN defined, SHALL add output err_cnt [15:0]: saturating at 0xFFFF, incremented on each CONFIRM->HUNT abort and each LOCKED->HUNT loss, cleared by reset.
REQ-026 Without TMDS_RX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 Package tmds_pkg SHALL hold the symbol width (10), the four token constants, and the state enum.
REQ-028 The combinational symbol decode (REQ-012, REQ-017) SHALL be sub-module tmds_symbol_decode: input 10-bit symbol; outputs data[7:0], ctrl[1:0], is_token.

Verification
REQ-029 Reset: hold rst_in 3 clocks with random serial_in -> locked=0, sym_valid=0, all outputs 0.
REQ-030 Lock: 3 random bits, then 8x 0x354 -> locked=1 after the 8th token; first sym_valid shows de_out=0, ctrl_out=00; next pulse exactly 10 clocks later.
REQ-031 Decode after lock: 0x100 -> data_out=0x00, de_out=1; 0x2FF -> data_out=0xFE; 0x2AB -> de_out=0, ctrl_out=11.
REQ-032 Abort: 5x 0x154 then 0x100 -> stays unlocked, returns to HUNT; err_cnt=1 when TMDS_RX_ERR_CNT_EN is defined.
REQ-033 Loss: after lock, 1024 consecutive 0x100 -> 1024 sym_valid pulses, then locked=0; a token at symbol 1023 instead keeps lock.
REQ-034 Mid-operation reset: assert rst_in at phase 5 while LOCKED -> locked=0 next clock; relock needs 8 fresh tokens.
